// File: rtl/frame_rx10bit.sv
// 10-bit serial frame receiver: start bit, 9 data bits + parity bit (LSB first), stop bit.
// Optional parity checking is enabled by defining PARITY_CHECK_EN; the default build reports par_err = 0.
module frame_rx10bit #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx_in,
    output logic [9:0] d_out,
    output logic       valid,
    output logic       par_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            sync1;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic [9:0]      shift_reg;
    logic            hold_low;
    logic            sample_hit;
    logic            shift_en;
    logic            load_frame;
    logic            bad_stop;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // START samples at half a bit period so that DATA and STOP samples land mid-bit.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        load_frame = 1'b0;
        bad_stop   = 1'b0;
        sample_hit = (state == START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
        case (state)
            IDLE: begin
                if (!rxs && !hold_low) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_hit) begin
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_hit) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd9) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (sample_hit) begin
                    load_frame = rxs;
                    bad_stop   = !rxs;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt     <= '0;
            bit_cnt <= 4'd0;
        end else begin
            if (state == IDLE || sample_hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state != DATA) begin
                bit_cnt <= 4'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // After a bad stop bit the line may be held low (break); wait for a high before re-arming.
    always_ff @(posedge clk) begin
        if (clr) begin
            hold_low <= 1'b0;
        end else if (bad_stop) begin
            hold_low <= 1'b1;
        end else if (state == IDLE && rxs) begin
            hold_low <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            shift_reg <= 10'h000;
            d_out     <= 10'h000;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= load_frame;
            frame_err <= bad_stop;
            if (shift_en) begin
                shift_reg <= {rxs, shift_reg[9:1]};
            end
            if (load_frame) begin
                d_out <= shift_reg;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            par_err <= 1'b0;
        end else if (load_frame) begin
            par_err <= ^shift_reg;
        end
    end
`else
    assign par_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_frame_rx10bit.sv
// Self-checking bench for frame_rx10bit at CLKS_PER_BIT=4; expected frames are queued when
// sent and compared when valid pulses. Parity expectations follow PARITY_CHECK_EN.
module tb_frame_rx10bit;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rx_in = 1'b1;
    logic [9:0] d_out;
    logic       valid;
    logic       par_err;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_lat = 0;
    bit lat_taken = 1'b0;
    int valid_seen = 0;
    int ferr_seen = 0;
    logic [10:0] exp_q[$];

    frame_rx10bit #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .clr(clr),
        .rx_in(rx_in),
        .d_out(d_out),
        .valid(valid),
        .par_err(par_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic expPar(input logic [9:0] f);
        logic p;
        p = ^f;
`ifndef PARITY_CHECK_EN
        p = 1'b0;
`endif
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one full frame; leaves rx_in at the stop-bit level on return.
    task automatic applyStimulus(input logic [9:0] frame, input logic stop_bit);
        rx_in = 1'b0;
        start_cyc = cyc;
        waitCycles(C);
        for (int i = 0; i < 10; i++) begin
            rx_in = frame[i];
            waitCycles(C);
        end
        rx_in = stop_bit;
        waitCycles(C);
    endtask

    task automatic sendGood(input logic [9:0] frame);
        exp_q.push_back({expPar(frame), frame});
        applyStimulus(frame, 1'b1);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            valid_seen++;
            if (!lat_taken) begin
                first_lat = cyc - start_cyc;
                lat_taken = 1'b1;
            end
            if (exp_q.size() == 0) begin
                checkOutput("valid_unexpected", exp_q.size(), 1);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                checkOutput("d_out_at_valid", d_out, e[9:0]);
                checkOutput("par_err_at_valid", par_err, e[10]);
            end
        end
        if (frame_err) ferr_seen++;
    end

    initial begin
        $display("[TB] start");
        clr = 1'b1;
        rx_in = 1'b1;
        waitCycles(3);
        checkOutput("reset_d_out", d_out, 10'h000);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_par_err", par_err, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_busy", busy, 0);
        clr = 1'b0;
        waitCycles(4);

        // Basic good frame and latency
        sendGood(10'h0A5);
        waitCycles(2 * C);
        checkOutput("f0A5_valid_count", valid_seen, 1);
        checkOutput("f0A5_ferr_count", ferr_seen, 0);
        checkOutput("f0A5_d_out_hold", d_out, 10'h0A5);
        checkOutput("latency_in_window", (first_lat >= 48 && first_lat <= 50), 1);

        // Odd number of ones
        sendGood(10'h1FF);
        waitCycles(2 * C);
        checkOutput("f1FF_valid_count", valid_seen, 2);
        checkOutput("f1FF_par_hold", par_err, expPar(10'h1FF));

        // Good frame then bad stop bit, line held low afterwards (break)
        sendGood(10'h2C3);
        applyStimulus(10'h155, 1'b0);
        waitCycles(3 * C);
        checkOutput("break_busy", busy, 0);
        rx_in = 1'b1;
        waitCycles(2 * C);
        checkOutput("badstop_ferr_count", ferr_seen, 1);
        checkOutput("badstop_valid_count", valid_seen, 3);
        checkOutput("badstop_d_out_kept", d_out, 10'h2C3);
        checkOutput("badstop_par_kept", par_err, expPar(10'h2C3));

        // One-cycle glitch
        rx_in = 1'b0;
        waitCycles(1);
        rx_in = 1'b1;
        waitCycles(3 * C);
        checkOutput("glitch_busy", busy, 0);
        checkOutput("glitch_valid_count", valid_seen, 3);
        checkOutput("glitch_ferr_count", ferr_seen, 1);

        // clr during the 5th data bit aborts the frame
        rx_in = 1'b0;
        waitCycles(C);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            waitCycles(C);
        end
        rx_in = 1'b1;
        waitCycles(2);
        clr = 1'b1;
        waitCycles(1);
        checkOutput("abort_d_out", d_out, 10'h000);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", valid, 0);
        checkOutput("abort_frame_err", frame_err, 0);
        clr = 1'b0;
        waitCycles(3 * C);
        checkOutput("abort_valid_count", valid_seen, 3);
        sendGood(10'h0F0);
        waitCycles(2 * C);
        checkOutput("after_abort_valid_count", valid_seen, 4);
        checkOutput("after_abort_d_out", d_out, 10'h0F0);

        // Back-to-back frames
        sendGood(10'h001);
        sendGood(10'h300);
        waitCycles(2 * C);
        checkOutput("b2b_valid_count", valid_seen, 6);
        checkOutput("b2b_d_out", d_out, 10'h300);
        checkOutput("b2b_ferr_count", ferr_seen, 1);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_rx10bit.md
FRAME_RX10BIT -- requirements
Module: frame_rx10bit

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit period; legal values are even integers 4..1024.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk       input   1   system clock; all logic on the rising edge.
  clr       input   1   reset; synchronous, active-high.
  rx_in     input   1   asynchronous serial line; idles high.
  d_out     output  10  last good frame: [8:0] data bits, [9] parity bit; feeds the downstream 10-bit register.
  valid     output  1   one-cycle pulse when d_out has just been updated.
  par_err   output  1   parity status of the frame flagged by valid.
  frame_err output  1   one-cycle pulse when a frame's stop bit is sampled low.
  busy      output  1   high whenever state is not IDLE.

Function
REQ-003 rx_in SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized signal (rxs).
REQ-004 The frame format SHALL be: start bit (0), 10 payload bits sent LSB first (9 data bits, then 1 parity bit), stop bit (1).
REQ-005 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-006 In IDLE, the FSM SHALL go to START on the first cycle rxs=0 and clear the bit-period counter.
REQ-007 In START, after CLKS_PER_BIT/2 cycles (mid-bit), the FSM SHALL sample rxs.
  - If rxs=0, it SHALL go to DATA.
  - If rxs=1, it SHALL treat the start as a glitch, return to IDLE, and assert no outputs.
REQ-008 In DATA, it SHALL sample rxs every CLKS_PER_BIT cycles.
  - Each sample SHALL be shifted into a 10-bit shift register from the MSB side, so the first bit received lands in [0].
  - After the 10th sample, the FSM SHALL go to STOP.
REQ-009 In STOP, it SHALL sample rxs after CLKS_PER_BIT cycles.
  - If rxs=1, on the next edge d_out SHALL load the shift register, valid SHALL pulse for one cycle, and par_err SHALL be updated.
  - If rxs=0, on the next edge frame_err SHALL pulse for one cycle, and d_out, par_err and valid SHALL remain unchanged.
  - In both cases the FSM SHALL then return to IDLE.
REQ-010 After a stop sample of 0, the FSM SHALL stay in IDLE until rxs has been seen high at least once, so a held-low line (break) is never taken as a new start.
REQ-011 d_out SHALL hold its value between valid pulses.
REQ-012 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1, SHALL wrap to 0 on each sample point, and SHALL never overflow.
REQ-013 Latency: valid SHALL assert 11*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles (±1) after the rx_in falling edge of the start bit.
REQ-014 rx_in changes during the body of a bit period (not at the sample point) SHALL have no effect.

Reset
REQ-015 While clr=1 at a clk edge, the block SHALL set:
  - state = IDLE, both synchronizer flops = 1, counter = 0, shift register = 0;
  - d_out = 10'h000, valid = 0, par_err = 0, frame_err = 0, busy = 0.
REQ-016 clr asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception SHALL resume with the next start bit after clr deasserts.
REQ-017 clr SHALL take priority over all other events in the same cycle.

Configuration
REQ-018 Macro PARITY_CHECK_EN.
  - When defined: par_err SHALL equal the XOR of all 10 received bits (even parity expected; error when the count of ones is odd).
  - When undefined: par_err SHALL be constant 0 and no parity logic SHALL be synthesized; d_out[9] SHALL still carry the received bit.

Verification (CLKS_PER_BIT=4, PARITY_CHECK_EN defined unless noted)
REQ-019 Frame with data 9'h0A5 and parity bit 0 (four ones) → one valid pulse, d_out=10'h0A5, par_err=0, frame_err=0.
REQ-020 Frame with data 9'h1FF and parity bit 0 (nine ones) → valid pulse, d_out=10'h1FF, par_err=1; rebuilt without the macro → par_err=0.
REQ-021 Good frame 10'h2C3, then a frame 10'h155 with stop bit 0 → frame_err pulses once, no valid pulse, d_out stays 10'h2C3.
REQ-022 rx_in low for 1 cycle only, then high → busy returns to 0, no valid, no frame_err.
REQ-023 clr pulsed during the 5th data bit of a frame → all outputs 0 the next cycle, no pulse for that frame; following frame 10'h0F0 → valid pulse, d_out=10'h0F0.
REQ-024 Two back-to-back frames 10'h001 then 10'h300, second start bit immediately after the first stop bit → two valid pulses, d_out=10'h001 then 10'h300.
